// File: rtl/rom_bus_arbiter.sv
// Shares the base SRAM between IF fetches and MEM loads/stores using fixed wait states.
// Optional fair arbitration is enabled by defining ROM_ARB_FAIR_EN.
module rom_bus_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int RAM_ADDR_W  = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  if_req,
    input  logic [31:0]           if_addr,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_sel,
    output logic [31:0]           if_rdata,
    output logic                  if_ready,
    output logic [31:0]           mem_rdata,
    output logic                  mem_ready,
    output logic                  stallreq_if,
    output logic                  stallreq_mem,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    output logic                  ram_wdata_oe,
    input  logic [31:0]           ram_rdata,
    output logic [3:0]            ram_be_n,
    output logic                  ram_ce_n,
    output logic                  ram_oe_n,
    output logic                  ram_we_n
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_WR_REC} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    own_mem_q, own_mem_d;
    logic                    kill_q, kill_d;
    logic [RAM_ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              sel_q, sel_d;
    logic [31:0]             if_rdata_q, if_rdata_d;
    logic [31:0]             mem_rdata_q, mem_rdata_d;
    logic                    if_ready_q, if_ready_d;
    logic                    mem_ready_q, mem_ready_d;
    logic                    grant_mem;
    logic                    last_mem_q, last_mem_d;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:RAM_ADDR_W+2], if_addr[1:0],
                                mem_addr[31:RAM_ADDR_W+2], mem_addr[1:0], last_mem_q};

`ifdef ROM_ARB_FAIR_EN
    assign grant_mem = mem_req & ~(if_req & last_mem_q);
`else
    assign grant_mem = mem_req;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        own_mem_d   = own_mem_q;
        kill_d      = kill_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        sel_d       = sel_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        last_mem_d  = last_mem_q;
        case (state_q)
            S_IDLE: begin
                if (mem_req || if_req) begin
                    own_mem_d  = grant_mem;
                    last_mem_d = grant_mem;
                    kill_d     = 1'b0;
                    cnt_d      = CNT_LOAD;
                    addr_d     = grant_mem ? mem_addr[RAM_ADDR_W+1:2] : if_addr[RAM_ADDR_W+1:2];
                    wdata_d    = mem_wdata;
                    // IF fetches always read the full word
                    sel_d      = grant_mem ? mem_sel : 4'hF;
                    state_d    = (grant_mem && mem_we) ? S_WR : S_RD;
                end
            end
            S_RD: begin
                if (!own_mem_q && flush) kill_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    if (own_mem_q) begin
                        mem_rdata_d = ram_rdata;
                        mem_ready_d = 1'b1;
                    end else if (!(kill_q || flush)) begin
                        if_rdata_d = ram_rdata;
                        if_ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WR: begin
                if (cnt_q == '0) state_d = S_WR_REC;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_WR_REC: begin
                mem_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            own_mem_q   <= 1'b0;
            kill_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            sel_q       <= 4'h0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            last_mem_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            own_mem_q   <= own_mem_d;
            kill_q      <= kill_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            sel_q       <= sel_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
            last_mem_q  <= last_mem_d;
        end
    end

    // Strobes decode straight from registered state so they never glitch on input changes
    assign ram_ce_n     = (state_q == S_IDLE);
    assign ram_oe_n     = (state_q != S_RD);
    assign ram_we_n     = (state_q != S_WR);
    assign ram_wdata_oe = (state_q == S_WR) || (state_q == S_WR_REC);
    assign ram_be_n     = (state_q == S_IDLE) ? 4'hF : ~sel_q;
    assign ram_addr     = addr_q;
    assign ram_wdata    = wdata_q;

    assign if_rdata     = if_rdata_q;
    assign if_ready     = if_ready_q;
    assign mem_rdata    = mem_rdata_q;
    assign mem_ready    = mem_ready_q;
    assign stallreq_if  = if_req & ~if_ready_q;
    assign stallreq_mem = mem_req & ~mem_ready_q;

endmodule
